// File: rtl/timing_generator.sv
// Beat generator: a free-running beat counter driving a one-hot timing vector for the control
// unit, with run/halt control, stall, programmable cycle length, early end and single-step.
module timing_generator #(
  parameter int unsigned NUM_T = 8,
  parameter int unsigned CNT_W = $clog2(NUM_T),
  parameter int unsigned CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             halt_i,
  input  logic             stall_i,
  input  logic             step_mode_i,
  input  logic             step_req_i,
  input  logic [CNT_W-1:0] t_max_i,
  input  logic             early_end_i,
  output logic [NUM_T-1:0] t_o,
  output logic [CNT_W-1:0] tcount_o,
  output logic             running_o,
  output logic             cycle_end_o,
  output logic [CYC_W-1:0] cycle_count_o
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [CNT_W-1:0] TLast = CNT_W'(NUM_T - 1);
  localparam logic [NUM_T-1:0] TFirst = {{(NUM_T-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [NUM_T-1:0] t_q, t_d;
  logic [CNT_W-1:0] tcount_q, tcount_d;
  logic [CNT_W-1:0] t_max_q, t_max_d;
  logic             running_q, running_d;
  logic             halt_pend_q, halt_pend_d;
  logic [CYC_W-1:0] cycle_count_q, cycle_count_d;

  logic [CNT_W-1:0] t_max_clamped;
  logic             adv;
  logic             last;
  logic             cycle_end;

  // Beat qualification: stall beats step_req, and the last beat is either t_max or early_end.
  always_comb begin
    t_max_clamped = (t_max_i > TLast) ? TLast : t_max_i;
    adv           = !stall_i && (!step_mode_i || step_req_i);
    last          = (tcount_q == t_max_q) || early_end_i;
    cycle_end     = running_q && adv && last;
  end

  // Next-state logic for the run/idle FSM and the beat counter.
  always_comb begin
    state_d       = state_q;
    t_d           = t_q;
    tcount_d      = tcount_q;
    t_max_d       = t_max_q;
    running_d     = running_q;
    halt_pend_d   = halt_pend_q;
    cycle_count_d = cycle_count_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StRun;
          running_d = 1'b1;
          tcount_d  = '0;
          t_d       = TFirst;
          t_max_d   = t_max_clamped;
        end
      end
      StRun: begin
        if (cycle_end) begin
          cycle_count_d = cycle_count_q + CYC_W'(1);
          tcount_d      = '0;
          if (halt_pend_q || halt_i) begin
            state_d     = StIdle;
            running_d   = 1'b0;
            t_d         = '0;
            halt_pend_d = 1'b0;
          end else begin
            t_d     = TFirst;
            t_max_d = t_max_clamped;
          end
        end else begin
          if (adv) begin
            tcount_d = tcount_q + CNT_W'(1);
            t_d      = t_q << 1;
          end
          // Remember the halt so it lands on the next cycle end even if halt drops.
          if (halt_i) begin
            halt_pend_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = StIdle;
        running_d = 1'b0;
        t_d       = '0;
        tcount_d  = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      t_q           <= '0;
      tcount_q      <= '0;
      t_max_q       <= TLast;
      running_q     <= 1'b0;
      halt_pend_q   <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      t_q           <= t_d;
      tcount_q      <= tcount_d;
      t_max_q       <= t_max_d;
      running_q     <= running_d;
      halt_pend_q   <= halt_pend_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign t_o           = t_q;
  assign tcount_o      = tcount_q;
  assign running_o     = running_q;
  assign cycle_end_o   = cycle_end;
  assign cycle_count_o = cycle_count_q;

endmodule

// File: tb/tb_timing_generator.sv
// Bench for timing_generator: a cycle-level reference model predicts the outputs for every
// clock; predictions go into a queue that a separate monitor drains and compares.
module tb_timing_generator;

  // Six beats so that a 3-bit t_max can exceed the last index and exercise clamping;
  // a 4-bit cycle counter so wrap-around is reached.
  localparam int unsigned NUM_T = 6;
  localparam int unsigned CNT_W = $clog2(NUM_T);
  localparam int unsigned CYC_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic             halt_i = 1'b0;
  logic             stall_i = 1'b0;
  logic             step_mode_i = 1'b0;
  logic             step_req_i = 1'b0;
  logic [CNT_W-1:0] t_max_i = '0;
  logic             early_end_i = 1'b0;
  logic [NUM_T-1:0] t_o;
  logic [CNT_W-1:0] tcount_o;
  logic             running_o;
  logic             cycle_end_o;
  logic [CYC_W-1:0] cycle_count_o;

  timing_generator #(
    .NUM_T(NUM_T),
    .CYC_W(CYC_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .halt_i       (halt_i),
    .stall_i      (stall_i),
    .step_mode_i  (step_mode_i),
    .step_req_i   (step_req_i),
    .t_max_i      (t_max_i),
    .early_end_i  (early_end_i),
    .t_o          (t_o),
    .tcount_o     (tcount_o),
    .running_o    (running_o),
    .cycle_end_o  (cycle_end_o),
    .cycle_count_o(cycle_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_T-1:0] t;
    logic [CNT_W-1:0] tc;
    logic             run;
    logic [CYC_W-1:0] cnt;
    logic             ce;
    int               cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // Reference model: beat index, cycle length, run flag, pending halt, completed cycles.
  bit m_run;
  bit m_hp;
  int m_beat;
  int m_tmax;
  int m_cnt;

  function automatic int clamp(input int v);
    return (v >= int'(NUM_T)) ? int'(NUM_T) - 1 : v;
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_hp   = 1'b0;
    m_beat = 0;
    m_tmax = NUM_T - 1;
    m_cnt  = 0;
  endtask

  // Called shortly after a rising edge: apply inputs, predict what the DUT shows until the
  // next edge, then advance the model across that edge.
  task automatic drive(input bit st, input bit hl, input bit sl, input bit sm, input bit sr,
                       input int tm, input bit ee);
    exp_t e;
    bit   adv;
    bit   last;
    bit   ce;
    int   tmv;
    start_i     = st;
    halt_i      = hl;
    stall_i     = sl;
    step_mode_i = sm;
    step_req_i  = sr;
    t_max_i     = CNT_W'(tm);
    early_end_i = ee;
    tmv  = int'(t_max_i);
    adv  = !sl && (!sm || sr);
    last = (m_beat == m_tmax) || ee;
    ce   = m_run && adv && last;
    e.t  = '0;
    if (m_run) e.t[m_beat] = 1'b1;
    e.tc  = CNT_W'(m_beat);
    e.run = m_run;
    e.cnt = CYC_W'(m_cnt);
    e.ce  = ce;
    e.cyc = cyc;
    sb_q.push_back(e);
    if (!m_run) begin
      if (st) begin
        m_run  = 1'b1;
        m_beat = 0;
        m_tmax = clamp(tmv);
      end
    end else if (ce) begin
      m_cnt  = (m_cnt + 1) % (1 << CYC_W);
      m_beat = 0;
      if (m_hp || hl) begin
        m_run = 1'b0;
        m_hp  = 1'b0;
      end else begin
        m_tmax = clamp(tmv);
      end
    end else begin
      if (adv) m_beat = m_beat + 1;
      if (hl) m_hp = 1'b1;
    end
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic idle(input int n, input int tm);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, tm, 0);
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (t_o !== '0 || tcount_o !== '0 || running_o !== 1'b0 || cycle_count_o !== '0 ||
        cycle_end_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset cyc%0d: got t=%h tc=%0d run=%b cnt=%0d ce=%b, want all zero",
               cyc, t_o, tcount_o, running_o, cycle_count_o, cycle_end_o);
    end
    model_reset();
    idle(2, 0);
    rst_n = 1'b1;
  endtask

  // Monitor: every falling edge, compare the DUT against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (t_o !== e.t || tcount_o !== e.tc || running_o !== e.run ||
            cycle_count_o !== e.cnt || cycle_end_o !== e.ce) begin
          n_fail++;
          $display("FAIL outputs cyc%0d: got t=%h tc=%0d run=%b cnt=%0d ce=%b, want t=%h tc=%0d run=%b cnt=%0d ce=%b",
                   e.cyc, t_o, tcount_o, running_o, cycle_count_o, cycle_end_o,
                   e.t, e.tc, e.run, e.cnt, e.ce);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(2, 7);

    // Full-length walk with t_max above the last beat: clamps to NUM_T-1, wraps.
    drive(1, 0, 0, 0, 0, 7, 0);
    for (int i = 0; i < 2 * NUM_T + 1; i++) drive(0, 0, 0, 0, 0, 7, 0);

    // t_max=3 takes effect at the next cycle start; stall holds beat 2 for four clocks.
    for (int i = 0; i < NUM_T; i++) drive(0, 0, 0, 0, 0, 3, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 3, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0, 3, 0);

    // Early end, with t_max changed mid-cycle.
    drive(0, 0, 0, 0, 0, 7, 0);
    drive(0, 0, 0, 0, 0, 7, 1);
    drive(0, 0, 1, 0, 0, 7, 1);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0, 7, (i == 2));

    // Halt pulse mid-cycle, ignored start while running, then restart.
    for (int i = 0; i < 8; i++) drive(i == 3, i == 1, 0, 0, 0, 3, 0);
    idle(3, 3);
    drive(0, 1, 1, 1, 1, 3, 1);
    drive(1, 0, 0, 0, 0, 3, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0, 3, 0);

    // Single step every fourth clock; one strobe collides with stall and is dropped.
    for (int i = 0; i < 40; i++) drive(0, 0, (i == 12), 1, (i % 4 == 0), 3, 0);

    // Reset while running, then one-beat machine cycles.
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 7, 0);
    async_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, i == 18, 0, 0, 0, 0, 0);
    idle(2, 0);

    // Randomised phases: free-run vs. step mode, with occasional resets.
    for (int ph = 0; ph < 12; ph++) begin
      bit sm;
      sm = (ph % 3 == 2);
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 399) == 0) begin
          async_reset();
        end else begin
          drive($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 3) == 0, sm, $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
        end
      end
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked predictions, want 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
